// File: rtl/dotmatrix_pkg.sv
// Shared constants, FSM state encoding and row-strobe decode for the dot-matrix scan receiver.
// Strobes are active-low: a legal strobe has exactly one bit at zero.
package dotmatrix_pkg;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam logic [ROWS-1:0] ROW_OFF = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    function automatic logic row_onehot_low(input logic [ROWS-1:0] row_n);
        int zeros;
        zeros = 0;
        for (int i = 0; i < ROWS; i++) begin
            if (!row_n[i]) zeros++;
        end
        return (zeros == 1);
    endfunction

endpackage

// File: rtl/row_settle.sv
// Tracks how long row_n has been unchanged and how long the display has been dark.
// stable is combinational from the current row_n; blank is registered with a saturating count.
module row_settle
    import dotmatrix_pkg::*;
#(
    parameter int unsigned SETTLE       = 2,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] row_n,
    output logic            stable,
    output logic            blank
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int BW = $clog2(BLANK_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE);
    localparam logic [BW-1:0] BLANK_MAX  = BW'(BLANK_CYCLES);

    logic [ROWS-1:0] row_prev_q, row_prev_d;
    logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
    logic [BW-1:0]   blank_cnt_q, blank_cnt_d;

    always_comb begin
        row_prev_d   = row_n;
        settle_cnt_d = settle_cnt_q;
        blank_cnt_d  = blank_cnt_q;
        if (row_n != row_prev_q) begin
            settle_cnt_d = '0;
        end else if (settle_cnt_q != SETTLE_MAX) begin
            settle_cnt_d = settle_cnt_q + 1'b1;
        end
        if (row_n != ROW_OFF) begin
            blank_cnt_d = '0;
        end else if (blank_cnt_q != BLANK_MAX) begin
            blank_cnt_d = blank_cnt_q + 1'b1;
        end
    end

    // Both counters saturate, so stable and blank stay asserted for as long as the condition holds.
    assign stable = (settle_cnt_d == SETTLE_MAX);
    assign blank  = (blank_cnt_q == BLANK_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_prev_q   <= ROW_OFF;
            settle_cnt_q <= '0;
            blank_cnt_q  <= '0;
        end else begin
            row_prev_q   <= row_prev_d;
            settle_cnt_q <= settle_cnt_d;
            blank_cnt_q  <= blank_cnt_d;
        end
    end

endmodule

// File: rtl/matrix_scan_rx.sv
// Rebuilds a red/green 8x8 frame from a multiplexed row scan; frame_valid rises SETTLE+3 cycles after the last row appears.
// Held frames wait for frame_ack; a frame completing while one is held unacked is dropped. MATRIX_SCAN_RX_STATS_EN adds frame_cnt/overrun.
module matrix_scan_rx
    import dotmatrix_pkg::*;
#(
    parameter int unsigned SETTLE       = 2,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ROWS-1:0]      row_n,
    input  logic [COLS-1:0]      colr,
    input  logic [COLS-1:0]      colg,
    output logic [ROWS*COLS-1:0] frame_r,
    output logic [ROWS*COLS-1:0] frame_g,
    output logic                 frame_valid,
    input  logic                 frame_ack,
    output logic                 row_err,
`ifdef MATRIX_SCAN_RX_STATS_EN
    output logic [15:0]          frame_cnt,
    output logic                 overrun,
`endif
    output logic                 blank
);

    state_e                state_q, state_d;
    logic [ROWS-1:0]       prev_q, prev_d;
    logic [ROWS-1:0]       cap_row_q, cap_row_d;
    logic [COLS-1:0]       cap_r_q, cap_r_d, cap_g_q, cap_g_d;
    logic [ROWS*COLS-1:0]  shadow_r_q, shadow_r_d, shadow_g_q, shadow_g_d;
    logic [ROWS*COLS-1:0]  frame_r_q, frame_r_d, frame_g_q, frame_g_d;
    logic [ROWS-1:0]       seen_q, seen_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  row_err_q, row_err_d;
    logic                  stable, cap_ld, row_wr, row_bad, complete, frame_load;

    row_settle #(
        .SETTLE       (SETTLE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_row_settle (
        .clk    (clk),
        .rst    (rst),
        .row_n  (row_n),
        .stable (stable),
        .blank  (blank)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (row_n != prev_q) state_d = ST_SETTLE;
            ST_SETTLE:  if (stable) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cap_ld  = (state_q == ST_SETTLE) && stable;
        row_wr  = (state_q == ST_CAPTURE) && row_onehot_low(cap_row_q);
        row_bad = (state_q == ST_CAPTURE) && !row_onehot_low(cap_row_q) && (cap_row_q != ROW_OFF);
    end

    // The strobe and columns are latched on the last settle cycle so the write can land
    // after the scanner has already moved on; prev holds through CAPTURE so that move is still seen in IDLE.
    always_comb begin
        prev_d        = (state_q == ST_CAPTURE) ? prev_q : row_n;
        cap_row_d     = cap_ld ? row_n : cap_row_q;
        cap_r_d       = cap_ld ? colr  : cap_r_q;
        cap_g_d       = cap_ld ? colg  : cap_g_q;
        shadow_r_d    = shadow_r_q;
        shadow_g_d    = shadow_g_q;
        complete      = (seen_q == {ROWS{1'b1}});
        frame_load    = complete && (!frame_valid_q || frame_ack);
        seen_d        = complete ? '0 : seen_q;
        if (row_wr) begin
            seen_d = seen_d | ~cap_row_q;
            for (int i = 0; i < ROWS; i++) begin
                if (!cap_row_q[i]) begin
                    shadow_r_d[i*COLS +: COLS] = cap_r_q;
                    shadow_g_d[i*COLS +: COLS] = cap_g_q;
                end
            end
        end
        if (blank) seen_d = '0;
        frame_valid_d = (frame_valid_q && !frame_ack) || frame_load;
        frame_r_d     = frame_load ? shadow_r_q : frame_r_q;
        frame_g_d     = frame_load ? shadow_g_q : frame_g_q;
        row_err_d     = row_bad;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q        <= ROW_OFF;
            cap_row_q     <= ROW_OFF;
            cap_r_q       <= '0;
            cap_g_q       <= '0;
            shadow_r_q    <= '0;
            shadow_g_q    <= '0;
            seen_q        <= '0;
            frame_r_q     <= '0;
            frame_g_q     <= '0;
            frame_valid_q <= 1'b0;
            row_err_q     <= 1'b0;
        end else begin
            prev_q        <= prev_d;
            cap_row_q     <= cap_row_d;
            cap_r_q       <= cap_r_d;
            cap_g_q       <= cap_g_d;
            shadow_r_q    <= shadow_r_d;
            shadow_g_q    <= shadow_g_d;
            seen_q        <= seen_d;
            frame_r_q     <= frame_r_d;
            frame_g_q     <= frame_g_d;
            frame_valid_q <= frame_valid_d;
            row_err_q     <= row_err_d;
        end
    end

    assign frame_r     = frame_r_q;
    assign frame_g     = frame_g_q;
    assign frame_valid = frame_valid_q;
    assign row_err     = row_err_q;

`ifdef MATRIX_SCAN_RX_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        overrun_q, overrun_d;

    always_comb begin
        frame_cnt_d = frame_load ? frame_cnt_q + 16'd1 : frame_cnt_q;
        overrun_d   = overrun_q || (complete && frame_valid_q && !frame_ack);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign overrun   = overrun_q;
`endif

endmodule

// File: tb/tb_matrix_scan_rx.sv
// Scoreboard bench for matrix_scan_rx: expected frames are queued as scans are driven and
// popped whenever the receiver presents a newly loaded frame.
module tb_matrix_scan_rx;

    typedef struct packed {
        logic [63:0] r;
        logic [63:0] g;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  row_n, colr, colg;
    logic [63:0] frame_r, frame_g;
    logic        frame_valid, frame_ack, row_err, blank;
`ifdef MATRIX_SCAN_RX_STATS_EN
    logic [15:0] frame_cnt;
    logic        overrun;
`endif

    frame_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     err_pulses = 0;
    logic   fv_prev = 1'b0;
    logic   ack_at_edge = 1'b0;

    always #5 clk = ~clk;

    matrix_scan_rx #(.SETTLE(2), .BLANK_CYCLES(1000)) dut (
        .clk         (clk),
        .rst         (rst),
        .row_n       (row_n),
        .colr        (colr),
        .colg        (colg),
        .frame_r     (frame_r),
        .frame_g     (frame_g),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .row_err     (row_err),
`ifdef MATRIX_SCAN_RX_STATS_EN
        .frame_cnt   (frame_cnt),
        .overrun     (overrun),
`endif
        .blank       (blank)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic frame_t rand_frame();
        frame_t f;
        f.r = {$urandom, $urandom};
        f.g = {$urandom, $urandom};
        return f;
    endfunction

    task automatic drive_row(input int idx, input logic [7:0] r, input logic [7:0] g, input int cyc);
        row_n = ~(8'h01 << idx);
        colr  = r;
        colg  = g;
        repeat (cyc) @(negedge clk);
    endtask

    // Rows 0..6 for 3 cycles each, row 7 held 5 cycles so the completion edge is the 5th.
    task automatic scan_frame(input frame_t f, input logic chk_lat, input logic ack_done);
        for (int i = 0; i < 7; i++) drive_row(i, f.r[8*i +: 8], f.g[8*i +: 8], 3);
        row_n = ~8'h80;
        colr  = f.r[63:56];
        colg  = f.g[63:56];
        repeat (4) @(negedge clk);
        if (chk_lat) check("latency_early", 64'(frame_valid), 64'd0);
        if (ack_done) frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        if (chk_lat || ack_done) check("latency_valid", 64'(frame_valid), 64'd1);
    endtask

    task automatic ack_pulse();
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check("ack_clears_valid", 64'(frame_valid), 64'd0);
    endtask

    always @(posedge clk) ack_at_edge <= frame_ack;

    always @(negedge clk) begin
        frame_t f;
        if (rst) begin
            fv_prev = 1'b0;
        end else begin
            if (row_err) err_pulses++;
            if (frame_valid && (!fv_prev || ack_at_edge)) begin
                check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    f = exp_q.pop_front();
                    check("sb_frame_r", frame_r, f.r);
                    check("sb_frame_g", frame_g, f.g);
                end
            end
            fv_prev = frame_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t fa, fb, fc, fd, fe;
        rst = 1'b1; row_n = 8'hFF; colr = '0; colg = '0; frame_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_frame_r", frame_r, 64'd0);
        check("rst_frame_g", frame_g, 64'd0);
        check("rst_frame_valid", 64'(frame_valid), 64'd0);
        check("rst_row_err", 64'(row_err), 64'd0);
        check("rst_blank", 64'(blank), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        fa.r = 64'h0303_0000_0000_C0C0;
        fa.g = 64'h0303_0030_3000_0000;
        exp_q.push_back(fa);
        scan_frame(fa, 1'b1, 1'b0);

        fb = rand_frame();
        fc = rand_frame();
        scan_frame(fb, 1'b0, 1'b0);
        scan_frame(fc, 1'b0, 1'b0);
        check("overrun_frame_r", frame_r, fa.r);
        check("overrun_frame_g", frame_g, fa.g);
        check("overrun_valid", 64'(frame_valid), 64'd1);
`ifdef MATRIX_SCAN_RX_STATS_EN
        check("overrun_flag", 64'(overrun), 64'd1);
        check("frame_cnt_1", 64'(frame_cnt), 64'd1);
`endif
        ack_pulse();

        fd = rand_frame();
        exp_q.push_back(fd);
        scan_frame(fd, 1'b0, 1'b0);
        fe = rand_frame();
        exp_q.push_back(fe);
        scan_frame(fe, 1'b0, 1'b1);
`ifdef MATRIX_SCAN_RX_STATS_EN
        check("frame_cnt_3", 64'(frame_cnt), 64'd3);
`endif
        ack_pulse();

        err_pulses = 0;
        row_n = 8'hF0;
        repeat (4) @(negedge clk);
        for (int i = 4; i < 8; i++) drive_row(i, 8'hAA, 8'h55, 3);
        repeat (6) @(negedge clk);
        check("row_err_pulses", 64'(err_pulses), 64'd1);
        check("illegal_no_seen", 64'(frame_valid), 64'd0);

        row_n = 8'hFF;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (k == 999) check("blank_999", 64'(blank), 64'd0);
            if (k == 1000) check("blank_1000", 64'(blank), 64'd1);
        end
        row_n = 8'hFE;
        @(negedge clk);
        check("blank_clear", 64'(blank), 64'd0);
        repeat (2) @(negedge clk);
        for (int i = 1; i < 4; i++) drive_row(i, 8'h11, 8'h22, 3);
        repeat (6) @(negedge clk);
        check("blank_clears_seen", 64'(frame_valid), 64'd0);

        for (int i = 0; i < 5; i++) drive_row(i, 8'h33, 8'h44, 3);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_frame_r", frame_r, 64'd0);
        check("midrst_frame_g", frame_g, 64'd0);
        rst = 1'b0;
        for (int i = 5; i < 8; i++) drive_row(i, 8'h66, 8'h77, 3);
        repeat (6) @(negedge clk);
        check("midrst_no_frame", 64'(frame_valid), 64'd0);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
